// File: rtl/mulu_radix16.sv
// Iterative unsigned radix-16 multiplier that retires 4 multiplier bits per cycle.
// It produces the full 2*WIDTH-bit product.
// It shares the en/ready/vout/pause handshake with the radix-16 divider.
// Optional build macro: MULU_RADIX16_EARLY_TERM_EN stops after the highest
// non-zero multiplier nibble and realigns the product on the final edge.
//
// Handshake: an operation is accepted on a rising edge with en=1, ready=1 and
// pause=0. vout is a one-cycle pulse, held across paused edges. prod_hi and
// prod_lo are valid while vout=1 and stay stable until the next accept.
module mulu_radix16 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pause,
  input  logic             en,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             ready,
  output logic [WIDTH-1:0] prod_lo,
  output logic [WIDTH-1:0] prod_hi,
  output logic             vout
);

  localparam int N  = WIDTH / 4;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_FULL = CW'(N - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic              accept;
  logic              step;
  logic              done;

  logic [WIDTH-1:0]  a_q;
  logic [WIDTH+3:0]  p_hi_q;
  logic [WIDTH-1:0]  p_lo_q;
  logic [CW-1:0]     cnt_q;
  logic              vout_q;
  logic [CW-1:0]     last_sel;

  logic [3:0]        nib;
  logic [WIDTH+3:0]  a_ext;
  logic [WIDTH+3:0]  a_mult;
  logic [WIDTH+3:0]  sum;
  logic [WIDTH+3:0]  step_hi;
  logic [WIDTH-1:0]  step_lo;
  logic [2*WIDTH+3:0] final_p;

`ifdef MULU_RADIX16_EARLY_TERM_EN
  logic [CW-1:0]     last_q;
  logic [CW-1:0]     k_in;
  logic [CW-1:0]     shamt;

  // Index of the highest non-zero multiplier nibble; 0 when the multiplier is 0.
  always_comb begin
    k_in = '0;
    for (int i = 0; i < N; i++) begin
      if (multiplier[4*i +: 4] != 4'd0) k_in = CW'(i);
    end
  end

  assign last_sel = last_q;
  assign shamt    = LAST_FULL - last_q;
  // A short run leaves the product 4*(N-1-k) bits too high, so shift it back down.
  assign final_p  = {step_hi, step_lo} >> {shamt, 2'b00};
`else
  assign last_sel = LAST_FULL;
  assign final_p  = {step_hi, step_lo};
`endif

  // One radix-16 step: add nib*A from shifted copies of A, then shift P right by 4.
  always_comb begin
    nib     = p_lo_q[3:0];
    a_ext   = {4'b0000, a_q};
    a_mult  = (nib[0] ? a_ext        : '0)
            + (nib[1] ? (a_ext << 1) : '0)
            + (nib[2] ? (a_ext << 2) : '0)
            + (nib[3] ? (a_ext << 3) : '0);
    sum     = p_hi_q + a_mult;
    step_hi = {4'b0000, sum[WIDTH+3:4]};
    step_lo = {sum[3:0], p_lo_q[WIDTH-1:4]};
  end

  // Next-state and control strobes. A paused edge changes nothing.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    step     = 1'b0;
    done     = 1'b0;
    if (!pause) begin
      case (state)
        IDLE: begin
          if (en) begin
            accept   = 1'b1;
            state_nx = BUSY;
          end
        end
        BUSY: begin
          step = 1'b1;
          if (cnt_q == last_sel) begin
            done     = 1'b1;
            state_nx = IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Datapath registers: load on accept, iterate while busy, hold while paused.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q    <= '0;
      p_hi_q <= '0;
      p_lo_q <= '0;
      cnt_q  <= '0;
      vout_q <= 1'b0;
`ifdef MULU_RADIX16_EARLY_TERM_EN
      last_q <= '0;
`endif
    end else if (!pause) begin
      vout_q <= done;
      if (accept) begin
        a_q    <= multiplicand;
        p_lo_q <= multiplier;
        p_hi_q <= '0;
        cnt_q  <= '0;
`ifdef MULU_RADIX16_EARLY_TERM_EN
        last_q <= k_in;
`endif
      end else if (step) begin
        cnt_q <= cnt_q + 1'b1;
        if (done) begin
          {p_hi_q, p_lo_q} <= final_p;
        end else begin
          p_hi_q <= step_hi;
          p_lo_q <= step_lo;
        end
      end
    end
  end

  assign ready   = (state == IDLE);
  assign vout    = vout_q;
  assign prod_hi = p_hi_q[WIDTH-1:0];
  assign prod_lo = p_lo_q;

endmodule

// File: tb/tb_mulu_radix16.sv
// Testbench for mulu_radix16. The stimulus tasks push the expected product and
// latency into queues, and a monitor pops them when vout pulses.
module tb_mulu_radix16;

  localparam int W = 32;
  localparam int N = W / 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         pause;
  logic         en;
  logic [W-1:0] multiplicand;
  logic [W-1:0] multiplier;
  logic         ready;
  logic [W-1:0] prod_lo;
  logic [W-1:0] prod_hi;
  logic         vout;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [2*W-1:0] exp_q[$];
  int             lat_q[$];
  int             acc_q[$];

  mulu_radix16 #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .pause(pause), .en(en),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .ready(ready), .prod_lo(prod_lo), .prod_hi(prod_hi), .vout(vout)
  );

  // Clock generation and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: the number of nibbles the multiplier needs (the early-terminating build), or N.
  function automatic int iters(input logic [W-1:0] b);
`ifdef MULU_RADIX16_EARLY_TERM_EN
    int n = 1;
    logic [W-1:0] t = b;
    while (t >= 16) begin
      t = t >> 4;
      n++;
    end
    return n;
`else
    return N;
`endif
  endfunction

  function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] aa = {{W{1'b0}}, a};
    logic [2*W-1:0] bb = {{W{1'b0}}, b};
    return aa * bb;
  endfunction

  // Monitor: each new vout pulse is a completion, either rising or following an un-paused edge.
  logic prev_vout = 1'b0;
  logic prev_pause = 1'b0;
  always @(negedge clk) begin
    logic [2*W-1:0] e;
    int l;
    int a;
    if (reset) begin
      prev_vout  = 1'b0;
      prev_pause = 1'b0;
    end else begin
      if (vout && (!prev_vout || !prev_pause)) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_vout: got vout=1 want no result (cycle %0d)", cyc);
        end else begin
          e = exp_q.pop_front();
          l = lat_q.pop_front();
          a = acc_q.pop_front();
          check("product", {prod_hi, prod_lo}, e);
          check("latency", 64'(cyc - a), 64'(l));
        end
      end
      prev_vout  = vout;
      prev_pause = pause;
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ready) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: got ready=0 want 1 within 100 cycles");
    end
  endtask

  // Accept one operation. Pause is high for busy cycles ps..ps+plen-1.
  // If glitch is set, en pulses with junk operands during busy cycles 2..4.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int ps, input int plen, input bit glitch);
    int last;
    wait_ready();
    pause = 1'b0;
    multiplicand = a;
    multiplier   = b;
    en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    exp_q.push_back(ref_prod(a, b));
    lat_q.push_back(iters(b) + plen);
    acc_q.push_back(cyc);
    last = ps + plen - 1;
    if (glitch && last < 4) last = 4;
    for (int c = 1; c <= last; c++) begin
      pause = (plen > 0) && (c >= ps) && (c < ps + plen);
      if (glitch && c >= 2 && c <= 4) begin
        en = 1'b1;
        multiplicand = $urandom;
        multiplier   = $urandom;
      end else begin
        en = 1'b0;
      end
      check("busy_ready", 64'(ready), 64'd0);
      @(posedge clk); #1;
    end
    pause = 1'b0;
    en = 1'b0;
    wait_ready();
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int ps;
    int n;
    reset = 1'b1;
    pause = 1'b0;
    en = 1'b0;
    multiplicand = '0;
    multiplier = '0;
    #1;
    check("reset_ready", 64'(ready), 64'd1);
    check("reset_vout", 64'(vout), 64'd0);
    check("reset_prod", {prod_hi, prod_lo}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Small product, then check that the result holds while idle.
    run_op(32'h7, 32'h6, 1, 0, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("hold_prod", {prod_hi, prod_lo}, 64'h2A);

    // Maximum operands.
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 1'b0);

    // Three-cycle pause starting at the 4th busy cycle.
    run_op(32'h1234_5678, 32'h9ABC_DEF0, 4, 3, 1'b0);

    // en pulses while busy are ignored.
    run_op(32'hFFFF_0000, 32'h0001_0000, 1, 0, 1'b1);

    // Zero multiplier, then a back-to-back accept in the vout cycle.
    wait_ready();
    multiplicand = 32'h1234_5678;
    multiplier   = 32'h0;
    en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    exp_q.push_back(64'd0);
    lat_q.push_back(iters(32'h0));
    acc_q.push_back(cyc);
    n = 0;
    while (!vout && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("b2b_vout_seen", 64'(vout), 64'd1);
    check("b2b_ready_in_vout", 64'(ready), 64'd1);
    multiplicand = 32'd3;
    multiplier   = 32'd5;
    en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    exp_q.push_back(64'hF);
    lat_q.push_back(iters(32'd5));
    acc_q.push_back(cyc);
    check("b2b_accepted", 64'(ready), 64'd0);
    check("b2b_vout_cleared", 64'(vout), 64'd0);
    wait_ready();

    // Randomized operations with random pauses.
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 300)) : W'($urandom);
      ps = $urandom_range(1, iters(rb));
      run_op(ra, rb, ps, $urandom_range(0, 3), 1'b0);
    end
    repeat (2) begin
      @(posedge clk); #1;
    end

    // Asynchronous reset in the 3rd busy cycle aborts the operation.
    multiplicand = 32'hDEAD_BEEF;
    multiplier   = 32'hFFFF_FFFF;
    en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    check("abort_busy", 64'(ready), 64'd0);
    #2;
    reset = 1'b1;
    #1;
    check("abort_ready", 64'(ready), 64'd1);
    check("abort_vout", 64'(vout), 64'd0);
    check("abort_prod", {prod_hi, prod_lo}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
    end
    check("abort_idle", 64'(ready), 64'd1);

    check("drain", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mulu_radix16.md
Name: mulu_radix16

Overview:
- Iterative unsigned radix-16 multiplier. Retires 4 multiplier bits per cycle.
- Forms the full 2*WIDTH-bit product of two WIDTH-bit operands.
- Sits beside the radix-16 unsigned divider in the core's M-extension execute path.
- Uses the same en/ready/vout/pause handshake as the divider, so the issue logic drives both identically.

Parameters:
- WIDTH, 32: operand width. Must be a multiple of 4. N = WIDTH/4 iterations.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- pause  input  1  pipeline stall; freezes all state while high.
- en  input  1  start request; accepted only when ready=1 and pause=0.
- multiplicand  input  WIDTH  operand A, sampled on the accept edge.
- multiplier  input  WIDTH  operand B, sampled on the accept edge.
- ready  output  1  idle, able to accept.
- prod_lo  output  WIDTH  product bits [WIDTH-1:0].
- prod_hi  output  WIDTH  product bits [2*WIDTH-1:WIDTH].
- vout  output  1  one-cycle pulse: product valid.

Behaviour:
- Reset: asynchronous and active-high, per the fixed interface. While reset is high: ready=1, vout=0, prod_lo=0, prod_hi=0, iteration counter=0, internal registers=0. Reset mid-operation aborts the operation; no vout is produced.
- States:
  - IDLE (ready=1).
  - BUSY (ready=0).
- Accept: an edge with en=1, ready=1 and pause=0.
  - Latch A.
  - Load P_lo = B and P_hi = 0. P_hi is WIDTH+4 bits wide internally.
  - Clear the counter, set ready=0, move to BUSY.
- Iteration, each BUSY edge with pause=0:
  - nib = P_lo[3:0].
  - S = P_hi + A*nib, computed at WIDTH+4 bits. Multiples 1A..15A come from shift/add terms, not a generic multiplier.
  - P_hi <= S >> 4.
  - P_lo <= {S[3:0], P_lo[WIDTH-1:4]}.
  - Counter increments.
- Completion: the edge that performs the final iteration (counter reaching N-1):
  - Writes the final P.
  - Sets ready=1 and vout=1, returning to IDLE.
  - vout drops on the next edge unless a new completion occurs.
- Latency: vout is high in the cycle after the N-th un-paused BUSY edge. For WIDTH=32 with no pause, that is 8 cycles after the accept edge.
- Outputs:
  - prod_hi = P_hi[WIDTH-1:0] and prod_lo = P_lo.
  - Both are held stable from vout until the next accept.
  - Intermediate values are visible during BUSY; consumers must qualify them with vout.
- pause=1: all registers hold, including vout. A pending vout therefore stays high until the first un-paused edge. en is ignored while pause=1.
- en while BUSY: ignored. Operands are not re-sampled.
- en during the vout cycle: accepted, because ready=1 there. vout clears on that edge and the new operation starts (back-to-back).
- Arithmetic: the result is exact, A*B mod 2^(2*WIDTH). No overflow is possible. P_hi bits [WIDTH+3:WIDTH] are always 0 after the final iteration.

Optional Feature:
- Macro: MULU_RADIX16_EARLY_TERM_EN.
- Defined:
  - On accept, compute k = index of the highest non-zero nibble of B (k=0 if B=0).
  - Run k+1 iterations instead of N.
  - The completion edge additionally shifts the 2*WIDTH product right by 4*(N-1-k), so it is aligned identically to a full run.
  - Latency: k+1 cycles. B=0 or B<16 gives 1 cycle.
  - Results are identical to the non-feature build for all inputs.
- Undefined: always N iterations, with fixed latency.

Test Plan:
- A=0x00000007, B=0x00000006 -> prod_hi=0x00000000, prod_lo=0x0000002A. vout 8 cycles after accept; 1 cycle with EARLY_TERM_EN.
- A=0xFFFFFFFF, B=0xFFFFFFFF -> prod_hi=0xFFFFFFFE, prod_lo=0x00000001. Latency 8 in both builds.
- A=0x12345678, B=0x9ABCDEF0, pause high for 3 cycles starting at the 4th BUSY cycle -> vout at cycle 11. Product prod_hi=0x0B00EA4E, prod_lo=0x242D2080. ready stays 0 throughout.
- A=0x12345678, B=0 -> product 0. Then en held high in the vout cycle with A=3, B=5 -> second op accepted with no idle gap, result prod_lo=0x0000000F.
- Accept A=0xFFFF0000, B=0x00010000. Pulse en at cycles 2–4 -> ignored, result unchanged (prod_hi=0x0000FFFF, prod_lo=0x00000000).
- Assert reset at BUSY cycle 3 -> ready=1, vout=0, prod_lo=prod_hi=0 immediately (asynchronous). No vout afterwards.
